// File: rtl/flex_fifo_pkg.sv
// Shared helpers for flex_fifo: width derivation, parameter legality, operation encoding.
package flex_fifo_pkg;

  typedef enum logic [1:0] {
    OP_IDLE  = 2'b00,
    OP_WRITE = 2'b01,
    OP_READ  = 2'b10,
    OP_BOTH  = 2'b11
  } fifo_op_e;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // A pointer needs at least one bit even for a two-entry FIFO.
  function automatic int ptr_width(input int depth);
    return (clog2(depth) < 1) ? 1 : clog2(depth);
  endfunction

  // The count must be able to hold the value FDEPTH itself.
  function automatic int count_width(input int depth);
    return clog2(depth + 1);
  endfunction

  function automatic bit params_legal(input int dwidth, input int depth,
                                      input int af_thresh, input int ae_thresh);
    return (dwidth >= 1) && (depth >= 2) &&
           (af_thresh >= 1) && (af_thresh <= depth) &&
           (ae_thresh >= 0) && (ae_thresh <= depth - 1);
  endfunction

endpackage

// File: rtl/flex_fifo_mem.sv
// Storage array for flex_fifo: one synchronous write port, one asynchronous read port.
module flex_fifo_mem
  import flex_fifo_pkg::*;
#(
  parameter int DWIDTH = 9,
  parameter int DEPTH  = 5,
  parameter int AWIDTH = ptr_width(DEPTH)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [AWIDTH-1:0] i_waddr,
  input  logic [DWIDTH-1:0] i_wdata,
  input  logic [AWIDTH-1:0] i_raddr,
  output logic [DWIDTH-1:0] o_rdata
);

  // Contents are deliberately never reset; occupancy is tracked by the control logic.
  logic [DWIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/flex_fifo.sv
// Synchronous FIFO with arbitrary depth, threshold flags and sticky error flags.
// Define FLEX_FIFO_FWFT_EN for first-word-fall-through; otherwise data_o is a registered read.
module flex_fifo
  import flex_fifo_pkg::*;
#(
  parameter int DWIDTH    = 9,
  parameter int FDEPTH    = 5,
  parameter int AF_THRESH = FDEPTH - 1,
  parameter int AE_THRESH = 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [DWIDTH-1:0]                data_i,
  input  logic                             write_i,
  input  logic                             read_i,
  input  logic                             flush_i,
  output logic [DWIDTH-1:0]                data_o,
  output logic                             valid_o,
  output logic                             full_o,
  output logic                             empty_o,
  output logic                             almost_full_o,
  output logic                             almost_empty_o,
  output logic [count_width(FDEPTH)-1:0]   count_o,
  output logic                             overflow_o,
  output logic                             underflow_o
);

  localparam int PW = ptr_width(FDEPTH);
  localparam int CW = count_width(FDEPTH);

  localparam logic [PW-1:0] PTR_LAST = PW'(FDEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(FDEPTH);
  localparam logic [CW-1:0] CNT_AF   = CW'(AF_THRESH);
  localparam logic [CW-1:0] CNT_AE   = CW'(AE_THRESH);

  generate
    if (!params_legal(DWIDTH, FDEPTH, AF_THRESH, AE_THRESH)) begin : g_param_check
      $error("flex_fifo: illegal DWIDTH/FDEPTH/AF_THRESH/AE_THRESH combination");
    end
  endgenerate

  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              r_overflow;
  logic              r_underflow;

  logic              w_rd_accept;
  logic              w_wr_accept;
  logic              w_mem_we;
  logic [DWIDTH-1:0] w_mem_rdata;
  fifo_op_e          w_op;

  assign full_o         = (r_count == CNT_FULL);
  assign empty_o        = (r_count == '0);
  assign almost_full_o  = (r_count >= CNT_AF);
  assign almost_empty_o = (r_count <= CNT_AE);
  assign count_o        = r_count;
  assign overflow_o     = r_overflow;
  assign underflow_o    = r_underflow;

  // A read frees a slot in the same cycle, so a write on full is still taken alongside it.
  assign w_rd_accept = read_i && !empty_o;
  assign w_wr_accept = write_i && (!full_o || w_rd_accept);
  assign w_mem_we    = w_wr_accept && !flush_i;

  always_comb begin
    w_op = OP_IDLE;
    case ({w_rd_accept, w_wr_accept})
      2'b01:   w_op = OP_WRITE;
      2'b10:   w_op = OP_READ;
      2'b11:   w_op = OP_BOTH;
      default: w_op = OP_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (flush_i) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_accept) begin
        r_wr_ptr <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_rd_accept) begin
        r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + 1'b1;
      end
      case (w_op)
        OP_WRITE: r_count <= r_count + 1'b1;
        OP_READ:  r_count <= r_count - 1'b1;
        default:  r_count <= r_count;
      endcase
      if (write_i && !w_wr_accept) begin
        r_overflow <= 1'b1;
      end
      if (read_i && empty_o) begin
        r_underflow <= 1'b1;
      end
    end
  end

  flex_fifo_mem #(
    .DWIDTH (DWIDTH),
    .DEPTH  (FDEPTH),
    .AWIDTH (PW)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_mem_we),
    .i_waddr (r_wr_ptr),
    .i_wdata (data_i),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_mem_rdata)
  );

`ifdef FLEX_FIFO_FWFT_EN
  assign data_o  = w_mem_rdata;
  assign valid_o = !empty_o;
`else
  logic [DWIDTH-1:0] r_data;
  logic              r_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (flush_i) begin
      r_valid <= 1'b0;
    end else begin
      r_valid <= w_rd_accept;
      if (w_rd_accept) begin
        r_data <= w_mem_rdata;
      end
    end
  end

  assign data_o  = r_data;
  assign valid_o = r_valid;
`endif

endmodule

// File: tb/tb_flex_fifo.sv
// Directed, table-driven bench for flex_fifo (FDEPTH=5); honours FLEX_FIFO_FWFT_EN when defined.
module tb_flex_fifo;

  localparam int DW = 9;
  localparam int FD = 5;

  logic          clk;
  logic          rst_n;
  logic [DW-1:0] data_i;
  logic          write_i;
  logic          read_i;
  logic          flush_i;
  logic [DW-1:0] data_o;
  logic          valid_o;
  logic          full_o;
  logic          empty_o;
  logic          almost_full_o;
  logic          almost_empty_o;
  logic [2:0]    count_o;
  logic          overflow_o;
  logic          underflow_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0] last_rdata;

  flex_fifo #(.DWIDTH(DW), .FDEPTH(FD)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .data_i         (data_i),
    .write_i        (write_i),
    .read_i         (read_i),
    .flush_i        (flush_i),
    .data_o         (data_o),
    .valid_o        (valid_o),
    .full_o         (full_o),
    .empty_o        (empty_o),
    .almost_full_o  (almost_full_o),
    .almost_empty_o (almost_empty_o),
    .count_o        (count_o),
    .overflow_o     (overflow_o),
    .underflow_o    (underflow_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required end of test");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic          fl;
    logic          wr;
    logic          rd;
    logic [DW-1:0] din;
    int            cnt;
    logic          ovf;
    logic          unf;
    logic          racc;
    logic [DW-1:0] rdata;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mkv(logic fl, logic wr, logic rd, logic [DW-1:0] din, int cnt,
                               logic ovf, logic unf, logic racc, logic [DW-1:0] rdata);
    vec_t v;
    v.fl = fl; v.wr = wr; v.rd = rd; v.din = din; v.cnt = cnt;
    v.ovf = ovf; v.unf = unf; v.racc = racc; v.rdata = rdata;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_flags(input string tag, input int cnt, input logic ovf, input logic unf);
    chk({tag, "_count"}, 32'(count_o), 32'(cnt));
    chk({tag, "_full"},  32'(full_o),  32'(cnt == FD));
    chk({tag, "_empty"}, 32'(empty_o), 32'(cnt == 0));
    chk({tag, "_afull"}, 32'(almost_full_o),  32'(cnt >= FD - 1));
    chk({tag, "_aempty"},32'(almost_empty_o), 32'(cnt <= 1));
    chk({tag, "_ovf"},   32'(overflow_o),  32'(ovf));
    chk({tag, "_unf"},   32'(underflow_o), 32'(unf));
  endtask

  // Called at a negedge; returns at the following negedge with outputs checked.
  task automatic step(input string tag, input vec_t v);
    flush_i = v.fl; write_i = v.wr; read_i = v.rd; data_i = v.din;
`ifdef FLEX_FIFO_FWFT_EN
    if (v.racc) begin
      chk({tag, "_fwft_data"},  32'(data_o),  32'(v.rdata));
      chk({tag, "_fwft_valid"}, 32'(valid_o), 32'd1);
    end
`endif
    @(posedge clk);
    @(negedge clk);
    flush_i = 1'b0; write_i = 1'b0; read_i = 1'b0;
    chk_flags(tag, v.cnt, v.ovf, v.unf);
`ifdef FLEX_FIFO_FWFT_EN
    chk({tag, "_valid"}, 32'(valid_o), 32'(v.cnt != 0));
`else
    if (v.racc) last_rdata = v.rdata;
    chk({tag, "_valid"}, 32'(valid_o), 32'(v.racc));
    chk({tag, "_data"},  32'(data_o),  32'(last_rdata));
`endif
    $display("%s fl=%0b wr=%0b rd=%0b din=%03h -> count=%0d valid=%0b data=%03h ovf=%0b unf=%0b",
             tag, v.fl, v.wr, v.rd, v.din, count_o, valid_o, data_o, overflow_o, underflow_o);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_count"},  32'(count_o), 32'd0);
    chk({tag, "_empty"},  32'(empty_o), 32'd1);
    chk({tag, "_full"},   32'(full_o),  32'd0);
    chk({tag, "_aempty"}, 32'(almost_empty_o), 32'd1);
    chk({tag, "_afull"},  32'(almost_full_o),  32'd0);
    chk({tag, "_ovf"},    32'(overflow_o),  32'd0);
    chk({tag, "_unf"},    32'(underflow_o), 32'd0);
    chk({tag, "_valid"},  32'(valid_o),     32'd0);
`ifndef FLEX_FIFO_FWFT_EN
    chk({tag, "_data"},   32'(data_o),      32'd0);
`endif
  endtask

  initial begin
    // Full/overflow, drain/underflow, flush.
    for (int i = 0; i < 5; i++) vecs.push_back(mkv(0, 1, 0, 9'(9'h101 + i), i + 1, 0, 0, 0, 0));
    vecs.push_back(mkv(0, 1, 0, 9'h1FF, 5, 1, 0, 0, 0));
    for (int i = 0; i < 5; i++) vecs.push_back(mkv(0, 0, 1, 0, 4 - i, 1, 0, 1, 9'(9'h101 + i)));
    vecs.push_back(mkv(0, 0, 1, 0, 0, 1, 1, 0, 0));
    vecs.push_back(mkv(1, 0, 0, 0, 0, 0, 0, 0, 0));
    // Pointer wrap.
    for (int i = 0; i < 3; i++) vecs.push_back(mkv(0, 1, 0, 9'(i + 1), i + 1, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++) vecs.push_back(mkv(0, 0, 1, 0, 2 - i, 0, 0, 1, 9'(i + 1)));
    for (int i = 0; i < 4; i++) vecs.push_back(mkv(0, 1, 0, 9'(9'h00A + i), i + 1, 0, 0, 0, 0));
    for (int i = 0; i < 4; i++) vecs.push_back(mkv(0, 0, 1, 0, 3 - i, 0, 0, 1, 9'(9'h00A + i)));
    // Simultaneous read/write on full, then on empty.
    for (int i = 0; i < 5; i++) vecs.push_back(mkv(0, 1, 0, 9'(9'h021 + i), i + 1, 0, 0, 0, 0));
    vecs.push_back(mkv(0, 1, 1, 9'h055, 5, 0, 0, 1, 9'h021));
    for (int i = 0; i < 4; i++) vecs.push_back(mkv(0, 0, 1, 0, 4 - i, 0, 0, 1, 9'(9'h022 + i)));
    vecs.push_back(mkv(0, 0, 1, 0, 0, 0, 0, 1, 9'h055));
    vecs.push_back(mkv(0, 1, 1, 9'h077, 1, 0, 1, 0, 0));
    vecs.push_back(mkv(0, 0, 1, 0, 0, 0, 1, 1, 9'h077));
    // Flush at count 3 with both sticky flags set; write/read during flush are ignored.
    for (int i = 0; i < 5; i++) vecs.push_back(mkv(0, 1, 0, 9'(9'h0E1 + i), i + 1, 0, 1, 0, 0));
    vecs.push_back(mkv(0, 1, 0, 9'h1EE, 5, 1, 1, 0, 0));
    vecs.push_back(mkv(0, 0, 1, 0, 4, 1, 1, 1, 9'h0E1));
    vecs.push_back(mkv(0, 0, 1, 0, 3, 1, 1, 1, 9'h0E2));
    vecs.push_back(mkv(1, 1, 1, 9'h1AB, 0, 0, 0, 0, 0));
    vecs.push_back(mkv(0, 1, 0, 9'h033, 1, 0, 0, 0, 0));
    vecs.push_back(mkv(0, 0, 1, 0, 0, 0, 0, 1, 9'h033));
    vecs.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0));

    rst_n = 1'b0; flush_i = 1'b0; write_i = 1'b0; read_i = 1'b0; data_i = '0;
    last_rdata = '0;
    repeat (2) @(negedge clk);
    chk_reset_values("por");
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      step($sformatf("v%0d", i), vecs[i]);
    end

    // Asynchronous reset pulse with two entries stored.
    step("r0", mkv(0, 1, 0, 9'h0C1, 1, 0, 0, 0, 0));
    step("r1", mkv(0, 1, 0, 9'h0C2, 2, 0, 0, 0, 0));
    #2 rst_n = 1'b0;
    #1 chk_reset_values("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    last_rdata = '0;
    @(negedge clk);
    chk_reset_values("postrst");
    step("r2", mkv(0, 1, 0, 9'h0D1, 1, 0, 0, 0, 0));
    step("r3", mkv(0, 0, 1, 0, 0, 0, 0, 1, 9'h0D1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
